// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-FF synchronizer, mid-bit sampling, and an output register with valid/ack.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16,
  parameter int PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_ack,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            rx_frame_err,
  output logic            rx_overrun
`ifdef UART_RX_PARITY_EN
  ,output logic           rx_par_err
`endif
);

  localparam int SW = $clog2(OS > SB_TICK ? OS : SB_TICK);
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  if (OS < 8 || (OS & (OS - 1)) != 0 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_param_chk
    $error("uart_rx_oversample: OS must be a power of 2 >= 8 and PAR_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [1:0]      rx_sync;
  logic            rx_s;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] b;
  logic            brk;
  logic            take;

  assign rx_s = rx_sync[1];
  // a completed frame is accepted when the holding register is free or being drained this cycle
  assign take = !rx_valid || rx_ack;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PAR_ODD != 0);
  logic p;
  logic par_calc;
  assign par_calc = (^{b, p}) ^ PAR_SENSE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b            <= '0;
      brk          <= 1'b0;
      rx_dout      <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p            <= 1'b0;
      rx_par_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          // after a break, wait for the line to go high before arming again
          if (brk) begin
            if (rx_s) brk <= 1'b0;
          end else if (!rx_s) begin
            s_cnt <= '0;
            state <= START;
          end
        end
        START: if (s_tick) begin
          if (s_cnt == S_HALF) begin
            if (!rx_s) begin
              s_cnt <= '0;
              n_cnt <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        DATA: if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            b     <= {rx_s, b[DBIT-1:1]};
            if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              n_cnt <= n_cnt + 1'b1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            p     <= rx_s;
            state <= STOP;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
`endif
        STOP: if (s_tick) begin
          if (s_cnt == S_STOP) begin
            state        <= IDLE;
            rx_done_tick <= 1'b1;
            if (!rx_s) brk <= 1'b1;
            if (take) begin
              rx_dout      <= b;
              rx_frame_err <= !rx_s;
              rx_valid     <= 1'b1;
              rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
              rx_par_err   <= par_calc;
`endif
            end else begin
              rx_overrun <= 1'b1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: stimulus pushes expected frames, a monitor checks each rx_done_tick.
module tb_uart_rx_oversample;
  localparam int PAR_ODD = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_dout;
  logic       rx_valid, rx_done_tick, rx_frame_err, rx_overrun, rx_par_err;

  uart_rx_oversample #(.DBIT(8), .SB_TICK(16), .OS(16), .PAR_ODD(PAR_ODD)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .rx_ack(rx_ack),
    .rx_dout(rx_dout), .rx_valid(rx_valid), .rx_done_tick(rx_done_tick),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
`ifdef UART_RX_PARITY_EN
    ,.rx_par_err(rx_par_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign rx_par_err = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] dout;
    logic       valid, fe, ov, pe;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  // one-clk s_tick every 4 clocks, changed on the falling edge
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] cur();
    return {rx_dout, rx_valid, rx_frame_err, rx_overrun, rx_par_err};
  endfunction

  always @(negedge clk) begin
    if (!reset && rx_done_tick) begin
      exp_t e;
      n_done++;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("frame", {20'd0, cur()}, {20'd0, e});
      end
    end
    prev_done = rx_done_tick;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; ) begin
      @(posedge clk);
      if (s_tick) i++;
    end
  endtask

  function automatic logic par_ok(input logic [7:0] d);
    return (^d) ^ PAR_ODD[0];
  endfunction

  // one frame aligned to tick edges; optional rx_ack exactly on the stop-sample tick
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input logic ack_at_stop);
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < 8; k++) begin
      #1 rx = d[k];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = pbit;
    wait_ticks(16);
`endif
    #1 rx = stop;
    if (ack_at_stop) begin
      wait_ticks(7);
      do begin
        @(negedge clk);
        #1;
      end while (!s_tick);
      rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
      wait_ticks(8);
    end else begin
      wait_ticks(16);
    end
    #1 rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic ov, input logic pe);
    exp_t e;
    e.dout = d; e.valid = 1'b1; e.fe = fe; e.ov = ov; e.pe = pe;
    sbq.push_back(e);
  endtask

  initial begin
    int nd;
    repeat (4) @(posedge clk);
    #2 chk("reset_state", {19'd0, rx_done_tick, cur()}, 32'd0);
    @(negedge clk) reset = 1'b0;
    wait_ticks(4);

    // T1: plain frame
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, par_ok(8'hA5), 1'b1, 1'b0);
    chk("t1_done_count", n_done, 32'd1);
    ack();
    chk("t1_after_ack", {20'd0, cur()}, {20'd0, 8'hA5, 4'b0000});

    // T2: short low pulse is rejected as a glitch
    nd = n_done;
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(5);
    #1 rx = 1'b1;
    wait_ticks(40);
    chk("t2_glitch_no_done", n_done, nd);
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, par_ok(8'h3C), 1'b1, 1'b0);
    ack();

    // T3: framing error, then recovery
    expect_frame(8'h81, 1'b1, 1'b0, 1'b0);
    send_frame(8'h81, par_ok(8'h81), 1'b0, 1'b0);
    ack();
    chk("t3_fe_held", {20'd0, cur()}, {20'd0, 8'h81, 4'b0100});
    expect_frame(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, par_ok(8'h55), 1'b1, 1'b0);
    ack();

    // break: long low line gives exactly one error frame
    nd = n_done;
    expect_frame(8'h00, 1'b1, 1'b0, 1'b0);
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(400);
    #1 rx = 1'b1;
    wait_ticks(40);
    chk("brk_one_frame", n_done, nd + 1);
    chk("brk_state", {20'd0, cur()}, {20'd0, 8'h00, 4'b1100});
    ack();

    // T4: overrun
    expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, par_ok(8'h11), 1'b1, 1'b0);
    expect_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, par_ok(8'h22), 1'b1, 1'b0);
    ack();
    chk("t4_after_ack", {20'd0, cur()}, {20'd0, 8'h11, 4'b0000});

    // T5: ack coincident with completion accepts the new frame
    expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, par_ok(8'h11), 1'b1, 1'b0);
    expect_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, par_ok(8'h22), 1'b1, 1'b1);
    chk("t5_hold", {20'd0, cur()}, {20'd0, 8'h22, 4'b1000});

    // T6: reset during data bit 3
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < 3; k++) begin
      #1 rx = k[0];
      wait_ticks(16);
    end
    #1 rx = 1'b1;
    wait_ticks(5);
    #1 begin reset = 1'b1; rx = 1'b1; end
    #2 chk("t6_reset_outputs", {19'd0, rx_done_tick, cur()}, 32'd0);
    @(negedge clk) reset = 1'b0;
    wait_ticks(4);
    expect_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, par_ok(8'hF0), 1'b1, 1'b0);
    ack();

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    ack();
    expect_frame(8'h07, 1'b0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    ack();
`endif

    wait_ticks(4);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
